// File: rtl/ram_arbiter_if.sv
// Bus bundle between the RISC5 CPU port, the video refresh requester and the SRAM pins.
// The arbiter takes the slave modport; the CPU/video/SRAM environment takes the master modport.
interface ram_arbiter_if;
  logic [23:0] cpu_adr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        cpu_ben;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stallX;

  logic        vid_req;
  logic [21:0] vid_adr;
  logic        vid_ack;
  logic        vid_valid;
  logic [31:0] vid_data;

  logic [21:0] mem_adr;
  logic [3:0]  mem_be;
  logic        mem_oe;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_adr, cpu_rd, cpu_wr, cpu_ben, cpu_wdata,
    input  vid_req, vid_adr,
    input  mem_rdata,
    output cpu_rdata, stallX,
    output vid_ack, vid_valid, vid_data,
    output mem_adr, mem_be, mem_oe, mem_we, mem_wdata
  );

  modport master (
    output cpu_adr, cpu_rd, cpu_wr, cpu_ben, cpu_wdata,
    output vid_req, vid_adr,
    output mem_rdata,
    input  cpu_rdata, stallX,
    input  vid_ack, vid_valid, vid_data,
    input  mem_adr, mem_be, mem_oe, mem_we, mem_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Single-port SRAM arbiter sharing main memory between the CPU and the video refresh requester.
// Define ARB_FAIR_EN to enable the BURST cap and the CPU_WIN forced CPU window (GAP state).
module ram_arbiter #(
  parameter int BURST   = 8,
  parameter int CPU_WIN = 2
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  if (BURST < 1 || BURST > 255) begin : g_badBurst
    $error("ram_arbiter: BURST must be in 1..255");
  end
  if (CPU_WIN < 1 || CPU_WIN > 15) begin : g_badWin
    $error("ram_arbiter: CPU_WIN must be in 1..15");
  end

`ifdef ARB_FAIR_EN
  typedef enum logic [1:0] {CPU, VID, GAP} state_t;
`else
  typedef enum logic [0:0] {CPU, VID} state_t;
`endif

  state_t      r_state;
  logic        r_stallX;
  logic        r_vidValid;
  logic [31:0] r_vidData;

  logic        w_inVid;
  logic        w_vidAck;
  logic [3:0]  w_byteBe;

  assign w_inVid  = (r_state == VID);
  assign w_vidAck = w_inVid & bus.vid_req;
  assign w_byteBe = 4'b0001 << bus.cpu_adr[1:0];

  assign bus.stallX    = r_stallX;
  assign bus.vid_ack   = w_vidAck;
  assign bus.vid_valid = r_vidValid;
  assign bus.vid_data  = r_vidData;
  assign bus.cpu_rdata = bus.mem_rdata;

  // A simultaneous read and write is illegal; the write wins by suppressing the output enable.
  always_comb begin
    bus.mem_adr   = bus.cpu_adr[23:2];
    bus.mem_we    = bus.cpu_wr;
    bus.mem_oe    = bus.cpu_rd & ~bus.cpu_wr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_be    = bus.cpu_ben ? w_byteBe : 4'b1111;
    if (w_inVid) begin
      bus.mem_adr = bus.vid_adr;
      bus.mem_we  = 1'b0;
      bus.mem_oe  = 1'b1;
      bus.mem_be  = 4'b1111;
    end
  end

`ifdef ARB_FAIR_EN
  localparam logic [7:0] BURST_CNT = 8'(BURST);
  localparam logic [3:0] WIN_CNT   = 4'(CPU_WIN);

  logic [7:0] r_burstCnt;
  logic [3:0] r_winCnt;
  logic [7:0] w_burstNext;

  assign w_burstNext = r_burstCnt + {7'd0, w_vidAck};

  // The cap looks at the count including this cycle's ack, so the last acked word is also the last VID cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CPU;
      r_stallX   <= 1'b0;
      r_burstCnt <= 8'd0;
      r_winCnt   <= 4'd0;
    end else begin
      case (r_state)
        CPU: begin
          if (bus.vid_req) begin
            r_state    <= VID;
            r_stallX   <= 1'b1;
            r_burstCnt <= 8'd0;
          end
        end
        VID: begin
          r_burstCnt <= w_burstNext;
          if (w_burstNext == BURST_CNT) begin
            r_state  <= GAP;
            r_stallX <= 1'b0;
            r_winCnt <= WIN_CNT;
          end else if (!bus.vid_req) begin
            r_state  <= CPU;
            r_stallX <= 1'b0;
          end
        end
        GAP: begin
          r_winCnt <= r_winCnt - 4'd1;
          if (r_winCnt == 4'd1) begin
            if (bus.vid_req) begin
              r_state    <= VID;
              r_stallX   <= 1'b1;
              r_burstCnt <= 8'd0;
            end else begin
              r_state  <= CPU;
              r_stallX <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= CPU;
          r_stallX <= 1'b0;
        end
      endcase
    end
  end
`else
  // Strict video priority: VID is held for as long as the requester keeps asking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= CPU;
      r_stallX <= 1'b0;
    end else begin
      case (r_state)
        CPU: begin
          if (bus.vid_req) begin
            r_state  <= VID;
            r_stallX <= 1'b1;
          end
        end
        VID: begin
          if (!bus.vid_req) begin
            r_state  <= CPU;
            r_stallX <= 1'b0;
          end
        end
        default: begin
          r_state  <= CPU;
          r_stallX <= 1'b0;
        end
      endcase
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vidValid <= 1'b0;
      r_vidData  <= 32'd0;
    end else begin
      r_vidValid <= w_vidAck;
      if (w_vidAck) begin
        r_vidData <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: SRAM model, directed CPU/video vectors and a video-word scoreboard.
// Build with ARB_FAIR_EN defined to exercise the burst-cap / GAP sequence instead of strict priority.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ram_arbiter_if bus ();

  ram_arbiter #(.BURST(8), .CPU_WIN(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nAssert = 0;
  int nFail   = 0;

  logic [31:0] expQ [$];
  logic [31:0] sram [0:255];

  // Word i of the model memory: 1,2,3 in the first three words, C0DE00ii elsewhere.
  function automatic logic [31:0] expWord(input logic [7:0] idx);
    if (idx < 8'd3) return {24'd0, idx} + 32'd1;
    return 32'hC0DE0000 | {24'd0, idx};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) sram[i] <= expWord(8'(i));
  end

  assign bus.mem_rdata = sram[bus.mem_adr[7:0]];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_be[b]) sram[bus.mem_adr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic ben,
                               input logic [23:0] adr, input logic [31:0] wdata, input logic req);
    bus.cpu_rd    = rd;
    bus.cpu_wr    = wr;
    bus.cpu_ben   = ben;
    bus.cpu_adr   = adr;
    bus.cpu_wdata = wdata;
    bus.vid_req   = req;
  endtask

  // One bus cycle: an ack seen before the edge becomes an expected word and advances the requester.
  task automatic stepCycle();
    logic        ack;
    logic [31:0] e;
    #1;
    ack = bus.vid_ack;
    e   = expWord(bus.vid_adr[7:0]);
    @(posedge clk);
    #1;
    if (ack) begin
      expQ.push_back(e);
      bus.vid_adr = bus.vid_adr + 22'd1;
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.vid_valid) begin
      nAssert++;
      if (expQ.size() == 0) begin
        nFail++;
        $display("[TB] FAIL vid_data unexpected: got %h with vid_valid, required no word", bus.vid_data);
      end else begin
        logic [31:0] e;
        e = expQ.pop_front();
        if (bus.vid_data !== e) begin
          nFail++;
          $display("[TB] FAIL vid_data: got %h, required %h", bus.vid_data, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

  logic [3:0] laneBe [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    rst = 1'b1;
    bus.vid_adr = 22'h000000;
    applyStimulus(0, 0, 0, 24'h000000, 32'h0, 0);
    #2;
    checkOutput("reset stallX", {31'd0, bus.stallX}, 32'd0);
    checkOutput("reset vid_ack", {31'd0, bus.vid_ack}, 32'd0);
    checkOutput("reset vid_valid", {31'd0, bus.vid_valid}, 32'd0);
    checkOutput("reset vid_data", bus.vid_data, 32'd0);
    checkOutput("reset mem_be", {28'd0, bus.mem_be}, 32'hF);
    checkOutput("reset mem_we", {31'd0, bus.mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] CPU byte write with idle video");
    applyStimulus(0, 1, 1, 24'h000106, 32'hA5A5A5A5, 0);
    #1;
    checkOutput("bytewr mem_adr", {10'd0, bus.mem_adr}, 32'h41);
    checkOutput("bytewr mem_be", {28'd0, bus.mem_be}, 32'h4);
    checkOutput("bytewr mem_we", {31'd0, bus.mem_we}, 32'd1);
    checkOutput("bytewr mem_oe", {31'd0, bus.mem_oe}, 32'd0);
    checkOutput("bytewr mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
    checkOutput("bytewr stallX", {31'd0, bus.stallX}, 32'd0);
    stepCycle();

    applyStimulus(1, 0, 0, 24'h000104, 32'h0, 0);
    #1;
    checkOutput("readback mem_oe", {31'd0, bus.mem_oe}, 32'd1);
    checkOutput("readback mem_be", {28'd0, bus.mem_be}, 32'hF);
    checkOutput("readback cpu_rdata", bus.cpu_rdata, 32'hC0A50041);
    stepCycle();

    for (int o = 0; o < 4; o++) begin
      applyStimulus(1, 0, 1, 24'h000200 | 24'(o), 32'h0, 0);
      #1;
      checkOutput($sformatf("lane%0d mem_be", o), {28'd0, bus.mem_be}, {28'd0, laneBe[o]});
      stepCycle();
    end

    applyStimulus(1, 1, 0, 24'h0003FC, 32'h12345678, 0);
    #1;
    checkOutput("rd+wr mem_oe", {31'd0, bus.mem_oe}, 32'd0);
    checkOutput("rd+wr mem_we", {31'd0, bus.mem_we}, 32'd1);
    stepCycle();

    $display("[TB] video burst of 3");
    bus.vid_adr = 22'h3C000;
    applyStimulus(0, 0, 0, 24'h0, 32'h0, 1);
    #1;
    checkOutput("burst T stallX", {31'd0, bus.stallX}, 32'd0);
    checkOutput("burst T vid_ack", {31'd0, bus.vid_ack}, 32'd0);
    stepCycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, (k == 1), 0, 24'h0, 32'hFFFFFFFF, 1);
      #1;
      checkOutput($sformatf("burst T+%0d stallX", k + 1), {31'd0, bus.stallX}, 32'd1);
      checkOutput($sformatf("burst T+%0d vid_ack", k + 1), {31'd0, bus.vid_ack}, 32'd1);
      checkOutput($sformatf("burst T+%0d mem_adr", k + 1), {10'd0, bus.mem_adr}, 32'h3C000 + k);
      checkOutput($sformatf("burst T+%0d mem_oe", k + 1), {31'd0, bus.mem_oe}, 32'd1);
      checkOutput($sformatf("burst T+%0d mem_we", k + 1), {31'd0, bus.mem_we}, 32'd0);
      checkOutput($sformatf("burst T+%0d vid_valid", k + 1), {31'd0, bus.vid_valid}, (k > 0) ? 32'd1 : 32'd0);
      stepCycle();
    end
    applyStimulus(0, 0, 0, 24'h0, 32'h0, 0);
    #1;
    checkOutput("burst exit stallX", {31'd0, bus.stallX}, 32'd1);
    checkOutput("burst exit vid_ack", {31'd0, bus.vid_ack}, 32'd0);
    checkOutput("burst exit vid_valid", {31'd0, bus.vid_valid}, 32'd1);
    stepCycle();
    #1;
    checkOutput("burst after stallX", {31'd0, bus.stallX}, 32'd0);
    checkOutput("burst after vid_valid", {31'd0, bus.vid_valid}, 32'd0);
    stepCycle();

    $display("[TB] CPU read and video request collide");
    bus.vid_adr = 22'h3C010;
    applyStimulus(1, 0, 0, 24'h000008, 32'h0, 1);
    #1;
    checkOutput("collide mem_oe", {31'd0, bus.mem_oe}, 32'd1);
    checkOutput("collide mem_adr", {10'd0, bus.mem_adr}, 32'h2);
    checkOutput("collide cpu_rdata", bus.cpu_rdata, 32'h3);
    checkOutput("collide stallX", {31'd0, bus.stallX}, 32'd0);
    checkOutput("collide vid_ack", {31'd0, bus.vid_ack}, 32'd0);
    stepCycle();
    applyStimulus(0, 0, 0, 24'h0, 32'h0, 1);
    #1;
    checkOutput("collide+1 stallX", {31'd0, bus.stallX}, 32'd1);
    checkOutput("collide+1 vid_ack", {31'd0, bus.vid_ack}, 32'd1);
    checkOutput("collide+1 mem_adr", {10'd0, bus.mem_adr}, 32'h3C010);
    stepCycle();
    applyStimulus(0, 0, 0, 24'h0, 32'h0, 0);
    #1;
    checkOutput("collide exit vid_ack", {31'd0, bus.vid_ack}, 32'd0);
    stepCycle();
    stepCycle();

    $display("[TB] reset asserted mid-burst");
    bus.vid_adr = 22'h3C020;
    applyStimulus(0, 0, 0, 24'h0, 32'h0, 1);
    stepCycle();
    #1;
    checkOutput("rstburst pre vid_ack", {31'd0, bus.vid_ack}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstburst stallX", {31'd0, bus.stallX}, 32'd0);
    checkOutput("rstburst vid_ack", {31'd0, bus.vid_ack}, 32'd0);
    checkOutput("rstburst vid_valid", {31'd0, bus.vid_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.vid_req = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rstburst release stallX", {31'd0, bus.stallX}, 32'd0);
    stepCycle();
    #1;
    checkOutput("rstburst after stallX", {31'd0, bus.stallX}, 32'd0);
    checkOutput("rstburst after vid_valid", {31'd0, bus.vid_valid}, 32'd0);
    stepCycle();

`ifdef ARB_FAIR_EN
    $display("[TB] fair build, continuous video request");
    bus.vid_adr = 22'h3C080;
    applyStimulus(1, 0, 0, 24'h000008, 32'h0, 1);
    stepCycle();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) begin
        #1;
        checkOutput($sformatf("fair p%0d w%0d stallX", p, i), {31'd0, bus.stallX}, 32'd1);
        checkOutput($sformatf("fair p%0d w%0d vid_ack", p, i), {31'd0, bus.vid_ack}, 32'd1);
        stepCycle();
      end
      for (int g = 0; g < 2; g++) begin
        #1;
        checkOutput($sformatf("fair p%0d gap%0d stallX", p, g), {31'd0, bus.stallX}, 32'd0);
        checkOutput($sformatf("fair p%0d gap%0d vid_ack", p, g), {31'd0, bus.vid_ack}, 32'd0);
        checkOutput($sformatf("fair p%0d gap%0d cpu_rdata", p, g), bus.cpu_rdata, 32'h3);
        stepCycle();
      end
    end
    applyStimulus(0, 0, 0, 24'h0, 32'h0, 0);
    #1;
    checkOutput("fair exit stallX", {31'd0, bus.stallX}, 32'd1);
    checkOutput("fair exit vid_ack", {31'd0, bus.vid_ack}, 32'd0);
    stepCycle();
    stepCycle();
`else
    $display("[TB] strict priority, 100 cycles of video request");
    bus.vid_adr = 22'h3C080;
    applyStimulus(0, 0, 0, 24'h0, 32'h0, 1);
    stepCycle();
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 1, 0, 24'h000010, 32'hDEADBEEF, 1);
      #1;
      checkOutput($sformatf("strict w%0d stallX", i), {31'd0, bus.stallX}, 32'd1);
      checkOutput($sformatf("strict w%0d vid_ack", i), {31'd0, bus.vid_ack}, 32'd1);
      checkOutput($sformatf("strict w%0d mem_we", i), {31'd0, bus.mem_we}, 32'd0);
      stepCycle();
    end
    applyStimulus(0, 0, 0, 24'h0, 32'h0, 0);
    #1;
    checkOutput("strict exit stallX", {31'd0, bus.stallX}, 32'd1);
    checkOutput("strict exit vid_ack", {31'd0, bus.vid_ack}, 32'd0);
    stepCycle();
    stepCycle();
`endif

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Single-port SRAM arbiter that shares the 32-bit asynchronous main memory between the RISC5 CPU data/instruction port and a video refresh requester. It sits between the CPU bus (adr/rd/wr/ben/outbus/inbus) and the SRAM pins. It pauses the CPU through `stallX` whenever the video requester owns the memory, and delivers video words through a registered read port.

## Interface

Parameters:
- `BURST`, 8: maximum consecutive video words before a forced CPU window (used only with `ARB_FAIR_EN`); range 1..255.
- `CPU_WIN`, 2: length in cycles of the forced CPU window; range 1..15.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `cpu_adr`  in  24  CPU byte address.
- `cpu_rd`  in  1  CPU read strobe.
- `cpu_wr`  in  1  CPU write strobe.
- `cpu_ben`  in  1  CPU byte access.
- `cpu_wdata`  in  32  CPU write data (already lane-replicated by the CPU).
- `cpu_rdata`  out  32  read data to the CPU `inbus`.
- `stallX`  out  1  CPU external stall.
- `vid_req`  in  1  video wants the word at `vid_adr`.
- `vid_adr`  in  22  video word address.
- `vid_ack`  out  1  video word read this cycle; the requester advances `vid_adr` after this edge.
- `vid_valid`  out  1  one-cycle pulse: `vid_data` holds the acked word.
- `vid_data`  out  32  registered video read data.
- `mem_adr`  out  22  SRAM word address.
- `mem_be`  out  4  SRAM byte enables, active-high.
- `mem_oe`  out  1  SRAM output enable.
- `mem_we`  out  1  SRAM write enable.
- `mem_wdata`  out  32  SRAM write data.
- `mem_rdata`  in  32  SRAM read data (combinational, same cycle).

## Operation

- FSM states:
  - CPU: bus owned by the CPU.
  - VID: bus owned by video.
  - GAP: forced CPU window.
- `stallX` = (state == VID). It is a pure flop decode, so it is never combinationally dependent on `cpu_rd`/`cpu_wr`.
- Transitions out of CPU:
  - CPU -> VID when `vid_req`=1 at the edge.
- Transitions out of VID:
  - VID -> CPU when `vid_req`=0 at the edge.
  - VID -> GAP when the granted-word counter reaches `BURST` at the edge (fair build only). This rule has priority over the `vid_req`=0 exit.
- Transitions out of GAP:
  - GAP -> CPU after `CPU_WIN` cycles.
  - GAP -> VID directly instead, if `vid_req`=1 on the last window cycle.
  - `vid_req` is ignored on earlier GAP cycles.
- Burst counter (8 bits):
  - Cleared on entry to VID.
  - Incremented on every `vid_ack`.
- Window counter (4 bits):
  - Loaded on entry to GAP.
  - Decremented each GAP cycle.
- Signals in CPU and GAP states:
  - `mem_adr` = `cpu_adr[23:2]`.
  - `mem_we` = `cpu_wr`.
  - `mem_oe` = `cpu_rd` & ~`cpu_wr`.
  - `mem_wdata` = `cpu_wdata`.
  - `mem_be` = 4'b1111 for word access.
  - For byte access, `mem_be` = one-hot of `cpu_adr[1:0]` (00->0001, 01->0010, 10->0100, 11->1000).
  - `vid_ack` = 0.
- Signals in VID state:
  - `mem_adr` = `vid_adr`.
  - `mem_oe` = 1, `mem_we` = 0, `mem_be` = 4'b1111.
  - `vid_ack` = `vid_req`.
  - CPU strobes are ignored; the CPU gates them with `stallX`.
- `cpu_rdata` = `mem_rdata` in all states. The CPU performs byte-lane extraction.
- Video data path: on an edge with `vid_ack`=1, `vid_data` <= `mem_rdata` and `vid_valid` <= 1; otherwise `vid_valid` <= 0.
- `cpu_rd` and `cpu_wr` both high is illegal. The write wins (`mem_oe` forced low).

## Timing

- Reset values:
  - state CPU; both counters 0.
  - `stallX`=0, `vid_ack`=0, `vid_valid`=0, `vid_data`=0.
  - `mem_we`/`mem_oe`/`mem_be` follow the CPU strobes.
- Reset asserted mid-burst: state returns to CPU asynchronously and `stallX` drops immediately. No pending video word is delivered.
- Latencies:
  - CPU access: zero added latency while in CPU/GAP; SRAM data is returned in the strobe cycle.
  - Video: `vid_req` rising at cycle T gives first `vid_ack` at T+1 and `vid_valid` at T+2.
  - A burst of N words occupies N+1 stalled cycles; the extra cycle is the exit cycle with `vid_req`=0.
- Exit cycle: the requester must drop `vid_req` in the cycle after its last ack. That cycle has `stallX`=1 and `vid_ack`=0.
- Simultaneous CPU strobe and `vid_req` in state CPU: the CPU access completes that cycle, and video owns the next cycle.
- Because `stallX` is registered, the CPU never sees a mid-cycle loss of the bus.

## Configuration

- `ARB_FAIR_EN` defined:
  - The burst cap `BURST` and GAP window `CPU_WIN` are active.
  - The CPU is guaranteed `CPU_WIN` bus cycles per `BURST`+`CPU_WIN` cycles.
- `ARB_FAIR_EN` undefined:
  - GAP state and both counters are removed.
  - Video has strict priority and holds VID as long as `vid_req`=1; the CPU may starve.

## Test plan

- Reset mid-burst:
  - Stimulus: assert `rst` while in VID with `vid_req`=1.
  - Response: `stallX`=0 and `vid_ack`=0 asynchronously; after release the state is CPU with `vid_valid`=0.
- CPU byte write, idle video:
  - Stimulus: `cpu_wr`=1, `cpu_ben`=1, `cpu_adr`=24'h000106, `cpu_wdata`=32'hA5A5A5A5.
  - Response: same cycle `mem_adr`=22'h000041, `mem_be`=4'b0100, `mem_we`=1, `stallX`=0.
- Video burst of 3, words 22'h3C000..3C002 preloaded with 1,2,3:
  - Stimulus: `vid_req` high at T.
  - Response: `vid_ack` at T+1..T+3; `vid_data` 1,2,3 with `vid_valid` at T+2..T+4; `stallX` high T+1..T+4.
- Fair build, `BURST`=8, `CPU_WIN`=2, continuous `vid_req`:
  - Response: a repeating pattern of 8 acked cycles followed by 2 cycles of `stallX`=0, with CPU reads completing in the gap.
- Non-fair build, continuous `vid_req` for 100 cycles:
  - Response: `stallX`=1 throughout, 100 acks, no CPU access.
- Collision:
  - Stimulus: `cpu_rd`=1 and `vid_req` rise in the same cycle.
  - Response: CPU read served that cycle (`mem_oe`=1 at the CPU address); `stallX` and `vid_ack` follow the next cycle.
